// File: rtl/rv32_hart_pc_sched.sv
// Per-hart PC sequencer for the barrel core: round-robin fetch issue over
// eligible harts, next-PC retire, and debug/boot PC override.
module rv32_hart_pc_sched #(
    parameter int unsigned     NUM_HARTS = 8,
    parameter int unsigned     HART_W    = $clog2(NUM_HARTS),
    parameter int unsigned     PC_W      = 32,
    parameter logic [PC_W-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_HARTS-1:0] hart_en,
    input  logic                 stall,
    output logic                 issue_valid,
    output logic [HART_W-1:0]    issue_hart,
    output logic [PC_W-1:0]      issue_pc,
    input  logic                 wb_valid,
    input  logic [HART_W-1:0]    wb_hart,
    input  logic                 wb_has_new_pc,
    input  logic [PC_W-1:0]      wb_next_pc,
    input  logic                 cfg_we,
    input  logic [HART_W-1:0]    cfg_hart,
    input  logic [PC_W-1:0]      cfg_pc,
    output logic [NUM_HARTS-1:0] inflight,
    output logic                 misalign_evt
);

    logic [PC_W-1:0]      r_pc [NUM_HARTS];
    logic [NUM_HARTS-1:0] r_inflight;
    logic [NUM_HARTS-1:0] r_discard;
    logic [HART_W-1:0]    r_rr_ptr;
    logic                 r_issue_valid;
    logic [HART_W-1:0]    r_issue_hart;
    logic [PC_W-1:0]      r_issue_pc;
    logic                 r_misalign;

    logic [NUM_HARTS-1:0] w_elig;
    logic                 w_found;
    logic [HART_W-1:0]    w_sel;
    logic                 w_issue;
    logic                 w_ret;
    logic                 w_ret_apply;
    logic [PC_W-1:0]      w_pc_nxt [NUM_HARTS];
    logic [NUM_HARTS-1:0] w_inf_nxt;
    logic [NUM_HARTS-1:0] w_dis_nxt;
    logic [PC_W-1:0]      w_wb_target;
    logic [PC_W-1:0]      w_cfg_target;
    logic                 w_unused_cfg_lsb;

    assign w_elig           = hart_en & ~r_inflight;
    assign w_issue          = w_found & ~stall;
    assign w_ret            = wb_valid & r_inflight[wb_hart];
    assign w_ret_apply      = w_ret & ~r_discard[wb_hart];
    assign w_wb_target      = {wb_next_pc[PC_W-1:2], 2'b00};
    assign w_cfg_target     = {cfg_pc[PC_W-1:2], 2'b00};
    assign w_unused_cfg_lsb = ^cfg_pc[1:0];

    // First eligible hart scanning upward from rr_ptr, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int k = 0; k < NUM_HARTS; k++) begin
            if (!w_found && w_elig[HART_W'(r_rr_ptr + HART_W'(k))]) begin
                w_found = 1'b1;
                w_sel   = HART_W'(r_rr_ptr + HART_W'(k));
            end
        end
    end

    // Per-hart next state; override is applied last so it wins over retire.
    always_comb begin
        for (int h = 0; h < NUM_HARTS; h++) begin
            w_pc_nxt[h]  = r_pc[h];
            w_inf_nxt[h] = r_inflight[h];
            w_dis_nxt[h] = r_discard[h];
            if (w_ret && (wb_hart == HART_W'(h))) begin
                w_inf_nxt[h] = 1'b0;
                w_dis_nxt[h] = 1'b0;
                if (!r_discard[h]) begin
                    w_pc_nxt[h] = wb_has_new_pc ? w_wb_target : r_pc[h] + PC_W'(4);
                end
            end
            if (w_issue && (w_sel == HART_W'(h))) begin
                w_inf_nxt[h] = 1'b1;
            end
            if (cfg_we && (cfg_hart == HART_W'(h))) begin
                w_pc_nxt[h] = w_cfg_target;
                if (w_inf_nxt[h]) begin
                    w_dis_nxt[h] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                r_pc[h] <= RESET_PC;
            end
            r_inflight    <= '0;
            r_discard     <= '0;
            r_rr_ptr      <= '0;
            r_issue_valid <= 1'b0;
            r_issue_hart  <= '0;
            r_issue_pc    <= '0;
            r_misalign    <= 1'b0;
        end else begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                r_pc[h] <= w_pc_nxt[h];
            end
            r_inflight <= w_inf_nxt;
            r_discard  <= w_dis_nxt;
            r_misalign <= w_ret_apply & wb_has_new_pc & (|wb_next_pc[1:0]);
            if (w_issue) begin
                r_issue_valid <= 1'b1;
                r_issue_hart  <= w_sel;
                r_issue_pc    <= r_pc[w_sel];
                r_rr_ptr      <= HART_W'(w_sel + 1'b1);
            end else begin
                r_issue_valid <= 1'b0;
            end
        end
    end

    assign issue_valid  = r_issue_valid;
    assign issue_hart   = r_issue_hart;
    assign issue_pc     = r_issue_pc;
    assign inflight     = r_inflight;
    assign misalign_evt = r_misalign;

endmodule

// File: tb/tb_rv32_hart_pc_sched.sv
// Directed table-driven bench for rv32_hart_pc_sched (8 harts, 32-bit PC).
module tb_rv32_hart_pc_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  hart_en;
    logic        stall;
    logic        issue_valid;
    logic [2:0]  issue_hart;
    logic [31:0] issue_pc;
    logic        wb_valid;
    logic [2:0]  wb_hart;
    logic        wb_has_new_pc;
    logic [31:0] wb_next_pc;
    logic        cfg_we;
    logic [2:0]  cfg_hart;
    logic [31:0] cfg_pc;
    logic [7:0]  inflight;
    logic        misalign_evt;

    int n_checks = 0;
    int n_fail   = 0;

    rv32_hart_pc_sched dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .hart_en       (hart_en),
        .stall         (stall),
        .issue_valid   (issue_valid),
        .issue_hart    (issue_hart),
        .issue_pc      (issue_pc),
        .wb_valid      (wb_valid),
        .wb_hart       (wb_hart),
        .wb_has_new_pc (wb_has_new_pc),
        .wb_next_pc    (wb_next_pc),
        .cfg_we        (cfg_we),
        .cfg_hart      (cfg_hart),
        .cfg_pc        (cfg_pc),
        .inflight      (inflight),
        .misalign_evt  (misalign_evt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  en;
        logic        st;
        logic        wv;
        logic [2:0]  wh;
        logic        wn;
        logic [31:0] wpc;
        logic        cw;
        logic [2:0]  ch;
        logic [31:0] cpc;
        logic        ev;
        logic [2:0]  eh;
        logic [31:0] epc;
        logic [7:0]  einf;
        logic        emis;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [7:0] en, input logic st,
                                input logic wv, input logic [2:0] wh, input logic wn, input logic [31:0] wpc,
                                input logic cw, input logic [2:0] ch, input logic [31:0] cpc,
                                input logic ev, input logic [2:0] eh, input logic [31:0] epc,
                                input logic [7:0] einf, input logic emis);
        vec_t v;
        v.en = en; v.st = st; v.wv = wv; v.wh = wh; v.wn = wn; v.wpc = wpc;
        v.cw = cw; v.ch = ch; v.cpc = cpc;
        v.ev = ev; v.eh = eh; v.epc = epc; v.einf = einf; v.emis = emis;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, clock it, then sample registered outputs.
    task automatic run_vec(input string tag, input vec_t v);
        hart_en = v.en; stall = v.st;
        wb_valid = v.wv; wb_hart = v.wh; wb_has_new_pc = v.wn; wb_next_pc = v.wpc;
        cfg_we = v.cw; cfg_hart = v.ch; cfg_pc = v.cpc;
        @(posedge clk);
        #1;
        check({tag, " issue_valid"}, 32'(issue_valid), 32'(v.ev));
        if (v.ev) begin
            check({tag, " issue_hart"}, 32'(issue_hart), 32'(v.eh));
            check({tag, " issue_pc"}, issue_pc, v.epc);
        end
        check({tag, " inflight"}, 32'(inflight), 32'(v.einf));
        check({tag, " misalign_evt"}, 32'(misalign_evt), 32'(v.emis));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " issue_valid"}, 32'(issue_valid), 32'd0);
        check({tag, " issue_hart"}, 32'(issue_hart), 32'd0);
        check({tag, " issue_pc"}, issue_pc, 32'd0);
        check({tag, " inflight"}, 32'(inflight), 32'd0);
        check({tag, " misalign_evt"}, 32'(misalign_evt), 32'd0);
    endtask

    initial begin
        vec_t hv;

        // Boot: all harts enabled, issue 0..7 at PC 0, then nothing left.
        for (int i = 0; i < 8; i++)
            add(8'hFF, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3'(i), 32'h0, 8'((16'd1 << (i + 1)) - 16'd1), 0);
        add(8'hFF, 0, 0, 0, 0, 0,          0, 0, 0, 0, 0, 0,          8'hFF, 0);
        // Sequential retire, redirect, misaligned redirect on hart 3.
        add(8'hFF, 0, 1, 3, 0, 0,          0, 0, 0, 0, 0, 0,          8'hF7, 0);
        add(8'hFF, 0, 0, 0, 0, 0,          0, 0, 0, 1, 3, 32'h4,      8'hFF, 0);
        add(8'hFF, 0, 1, 3, 1, 32'h100,    0, 0, 0, 0, 0, 0,          8'hF7, 0);
        add(8'hFF, 0, 0, 0, 0, 0,          0, 0, 0, 1, 3, 32'h100,    8'hFF, 0);
        add(8'hFF, 0, 1, 3, 1, 32'h102,    0, 0, 0, 0, 0, 0,          8'hF7, 1);
        add(8'hFF, 0, 0, 0, 0, 0,          0, 0, 0, 1, 3, 32'h100,    8'hFF, 0);
        // Sparse enable 0,2,5,7 with stall toggling (rr_ptr currently 4).
        add(8'hA5, 1, 1, 0, 0, 0,          0, 0, 0, 0, 0, 0,          8'hFE, 0);
        add(8'hA5, 1, 1, 2, 0, 0,          0, 0, 0, 0, 0, 0,          8'hFA, 0);
        add(8'hA5, 1, 1, 5, 0, 0,          0, 0, 0, 0, 0, 0,          8'hDA, 0);
        add(8'hA5, 1, 1, 7, 0, 0,          0, 0, 0, 0, 0, 0,          8'h5A, 0);
        add(8'hA5, 0, 0, 0, 0, 0,          0, 0, 0, 1, 5, 32'h4,      8'h7A, 0);
        add(8'hA5, 1, 0, 0, 0, 0,          0, 0, 0, 0, 0, 0,          8'h7A, 0);
        add(8'hA5, 0, 1, 5, 0, 0,          0, 0, 0, 1, 7, 32'h4,      8'hDA, 0);
        add(8'hA5, 1, 1, 7, 0, 0,          0, 0, 0, 0, 0, 0,          8'h5A, 0);
        add(8'hA5, 0, 0, 0, 0, 0,          0, 0, 0, 1, 0, 32'h4,      8'h5B, 0);
        add(8'hA5, 0, 0, 0, 0, 0,          0, 0, 0, 1, 2, 32'h4,      8'h5F, 0);
        add(8'hA5, 0, 0, 0, 0, 0,          0, 0, 0, 1, 5, 32'h8,      8'h7F, 0);
        add(8'hA5, 0, 0, 0, 0, 0,          0, 0, 0, 1, 7, 32'h8,      8'hFF, 0);
        add(8'hA5, 0, 0, 0, 0, 0,          0, 0, 0, 0, 0, 0,          8'hFF, 0);
        // Override of in-flight hart 2; its retire must be discarded once.
        add(8'hA5, 0, 0, 0, 0, 0,          1, 2, 32'h8003, 0, 0, 0,   8'hFF, 0);
        add(8'hA5, 0, 1, 2, 1, 32'h40,     0, 0, 0, 0, 0, 0,          8'hFB, 0);
        add(8'hA5, 0, 0, 0, 0, 0,          0, 0, 0, 1, 2, 32'h8000,   8'hFF, 0);
        add(8'hA5, 0, 1, 2, 0, 0,          0, 0, 0, 0, 0, 0,          8'hFB, 0);
        add(8'hA5, 0, 0, 0, 0, 0,          0, 0, 0, 1, 2, 32'h8004,   8'hFF, 0);
        // PC wrap on hart 0 and spurious retire for an idle hart.
        add(8'hA5, 0, 0, 0, 0, 0,          1, 0, 32'hFFFF_FFFC, 0, 0, 0, 8'hFF, 0);
        add(8'hA5, 0, 1, 0, 1, 32'h200,    0, 0, 0, 0, 0, 0,          8'hFE, 0);
        add(8'hA5, 0, 0, 0, 0, 0,          0, 0, 0, 1, 0, 32'hFFFF_FFFC, 8'hFF, 0);
        add(8'hA5, 0, 1, 0, 0, 0,          0, 0, 0, 0, 0, 0,          8'hFE, 0);
        add(8'hA5, 1, 1, 0, 1, 32'h333,    0, 0, 0, 0, 0, 0,          8'hFE, 0);
        add(8'hA5, 0, 0, 0, 0, 0,          0, 0, 0, 1, 0, 32'h0,      8'hFF, 0);
        // Hart 1: override while idle, while issuing, and same cycle as retire.
        add(8'hA5, 0, 1, 1, 1, 32'h500,    0, 0, 0, 0, 0, 0,          8'hFD, 0);
        add(8'hA5, 0, 0, 0, 0, 0,          1, 1, 32'h600, 0, 0, 0,    8'hFD, 0);
        add(8'hFF, 0, 0, 0, 0, 0,          0, 0, 0, 1, 1, 32'h600,    8'hFF, 0);
        add(8'hFF, 0, 1, 1, 0, 0,          0, 0, 0, 0, 0, 0,          8'hFD, 0);
        add(8'hFF, 0, 0, 0, 0, 0,          1, 1, 32'h700, 1, 1, 32'h604, 8'hFF, 0);
        add(8'hFF, 0, 1, 1, 0, 0,          0, 0, 0, 0, 0, 0,          8'hFD, 0);
        add(8'hFF, 0, 0, 0, 0, 0,          0, 0, 0, 1, 1, 32'h700,    8'hFF, 0);
        add(8'hFF, 0, 1, 1, 1, 32'h900,    1, 1, 32'hA00, 0, 0, 0,    8'hFD, 0);
        add(8'hFF, 0, 0, 0, 0, 0,          0, 0, 0, 1, 1, 32'hA00,    8'hFF, 0);
        add(8'hFF, 0, 1, 1, 0, 0,          0, 0, 0, 0, 0, 0,          8'hFD, 0);
        add(8'hFF, 0, 0, 0, 0, 0,          0, 0, 0, 1, 1, 32'hA04,    8'hFF, 0);

        rst_n = 1'b0; hart_en = 8'hFF; stall = 1'b0;
        wb_valid = 1'b0; wb_hart = '0; wb_has_new_pc = 1'b0; wb_next_pc = '0;
        cfg_we = 1'b0; cfg_hart = '0; cfg_pc = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Mid-operation async reset drops all in-flight state immediately.
        rst_n = 1'b0;
        #2;
        check_reset_outputs("midreset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Retire for a hart with inflight=0 is ignored; hart 3 issues at reset PC.
        hv = '{en: 8'h08, st: 0, wv: 1, wh: 3, wn: 1, wpc: 32'h106, cw: 0, ch: 0, cpc: 0,
               ev: 1, eh: 3, epc: 32'h0, einf: 8'h08, emis: 0};
        run_vec("post_rst_issue", hv);
        hv = '{en: 8'h08, st: 0, wv: 0, wh: 0, wn: 0, wpc: 0, cw: 0, ch: 0, cpc: 0,
               ev: 0, eh: 0, epc: 0, einf: 8'h08, emis: 0};
        run_vec("post_rst_idle", hv);
        // Disabling a hart does not cancel its pending retire.
        hv = '{en: 8'h00, st: 0, wv: 1, wh: 3, wn: 0, wpc: 0, cw: 0, ch: 0, cpc: 0,
               ev: 0, eh: 0, epc: 0, einf: 8'h00, emis: 0};
        run_vec("disabled_retire", hv);
        hv = '{en: 8'h08, st: 0, wv: 0, wh: 0, wn: 0, wpc: 0, cw: 0, ch: 0, cpc: 0,
               ev: 1, eh: 3, epc: 32'h4, einf: 8'h08, emis: 0};
        run_vec("reenable_issue", hv);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
